// File: rtl/fsqrt_stage_pkg.sv
// Shared FPU types and constants for the fsqrt execution stage.
package fsqrt_stage_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } float32_t;

    localparam logic [7:0]  EXP_INF     = 8'hFF;
    localparam int          QUEUE_DEPTH = 2;
    localparam logic [31:0] QNAN        = 32'h7FC0_0000;

endpackage

// File: rtl/fsqrt_stage_fsqrt.sv
// Combinational single-precision square root, round-to-nearest on the magnitude.
// Raises exception for any negative operand (including -0) or a NaN operand.
module fsqrt
    import fsqrt_stage_pkg::*;
(
    input  logic [31:0] x,
    output logic [31:0] y,
    output logic        exception
);

    float32_t           w_x;
    logic [23:0]        w_sig;
    logic signed [9:0]  w_exp;
    logic signed [9:0]  w_half;
    logic [24:0]        w_sig2;
    logic [47:0]        w_rad;
    logic [25:0]        w_rem;
    logic [25:0]        w_trial;
    logic [23:0]        w_root;
    logic [7:0]         w_res_exp;
    logic               w_round;
    logic               w_is_nan;

    assign w_x      = x;
    assign w_is_nan = (w_x.exp == EXP_INF) && (w_x.man != 23'd0);
    assign exception = w_x.sign || w_is_nan;

    always_comb begin
        w_sig = {1'b1, w_x.man};
        w_exp = $signed({2'b00, w_x.exp}) - 10'sd127;
        // Subnormals are normalised so the root sees a leading one at bit 23.
        if (w_x.exp == 8'd0) begin
            w_sig = {1'b0, w_x.man};
            w_exp = -10'sd126;
            for (int i = 0; i < 23; i++) begin
                if (!w_sig[23]) begin
                    w_sig = w_sig << 1;
                    w_exp = w_exp - 10'sd1;
                end
            end
        end
        if (w_exp[0]) begin
            w_sig2 = {w_sig, 1'b0};
            w_exp  = w_exp - 10'sd1;
        end else begin
            w_sig2 = {1'b0, w_sig};
        end
        w_half    = w_exp >>> 1;
        w_res_exp = 8'(w_half + 10'sd127);

        // Digit-by-digit root of sig2 * 2^23 yields a 24-bit root with bit 23 set.
        w_rad   = {w_sig2, 23'd0};
        w_rem   = '0;
        w_root  = '0;
        w_trial = '0;
        for (int i = 23; i >= 0; i--) begin
            w_rem   = {w_rem[23:0], w_rad[2*i +: 2]};
            w_trial = {w_root, 2'b01};
            if (w_rem >= w_trial) begin
                w_rem  = w_rem - w_trial;
                w_root = {w_root[22:0], 1'b1};
            end else begin
                w_root = {w_root[22:0], 1'b0};
            end
        end
        w_round = (w_rem > {2'b00, w_root});

        y = {1'b0, w_res_exp, w_root[22:0]} + {31'd0, w_round};
        if (w_is_nan) begin
            y = QNAN;
        end else if (w_x.sign) begin
            y = (x[30:0] == 31'd0) ? x : QNAN;
        end else if (w_x.exp == EXP_INF) begin
            y = x;
        end else if (x[30:0] == 31'd0) begin
            y = 32'd0;
        end
    end

endmodule

// File: rtl/fsqrt_stage.sv
// Handshaked sqrt stage: operand register, combinational fsqrt, 2-entry result queue.
// Optional FSQRT_STAGE_PERF_EN adds enqueue / exception event counters.
module fsqrt_stage
    import fsqrt_stage_pkg::*;
#(
    parameter int TAG_W = 5
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic             out_exc,
    output logic [TAG_W-1:0] out_tag,
    input  logic             flush,
    input  logic             clear_sticky,
`ifdef FSQRT_STAGE_PERF_EN
    output logic             sticky_exc,
    output logic [31:0]      perf_ops,
    output logic [31:0]      perf_exc
`else
    output logic             sticky_exc
`endif
);

    localparam logic [1:0] Q_FULL = 2'(QUEUE_DEPTH);

    logic             r_s1_valid;
    logic [31:0]      r_s1_x;
    logic [TAG_W-1:0] r_s1_tag;
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic             r_show_ptr;
    logic [1:0]       r_count;
    logic             r_sticky;

    logic [31:0]      w_y;
    logic             w_exc;
    logic             w_deq;
    logic             w_enq;
    logic             w_push;
    logic             w_accept;
    logic             w_head_ptr;
    logic [31:0]      w_slot_y   [QUEUE_DEPTH];
    logic             w_slot_exc [QUEUE_DEPTH];
    logic [TAG_W-1:0] w_slot_tag [QUEUE_DEPTH];

    fsqrt u_fsqrt (
        .x         (r_s1_x),
        .y         (w_y),
        .exception (w_exc)
    );

    assign out_valid = (r_count != 2'd0);
    assign w_deq     = out_valid && out_ready;
    assign w_enq     = r_s1_valid && ((r_count != Q_FULL) || w_deq);
    assign w_push    = w_enq && !flush;
    assign in_ready  = !r_s1_valid || w_enq;
    assign w_accept  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
        end else if (w_enq) begin
            r_s1_valid <= 1'b0;
        end
        if (rst) begin
            r_s1_x   <= '0;
            r_s1_tag <= '0;
        end else if (w_accept && !flush) begin
            r_s1_x   <= in_x;
            r_s1_tag <= in_tag;
        end
    end

    for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_slot
        logic [31:0]      r_y;
        logic             r_exc;
        logic [TAG_W-1:0] r_tag;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_y   <= '0;
                r_exc <= 1'b0;
                r_tag <= '0;
            end else if (w_push && (r_wr_ptr == 1'(gi))) begin
                r_y   <= w_y;
                r_exc <= w_exc;
                r_tag <= r_s1_tag;
            end
        end

        assign w_slot_y[gi]   = r_y;
        assign w_slot_exc[gi] = r_exc;
        assign w_slot_tag[gi] = r_tag;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_enq) r_wr_ptr <= ~r_wr_ptr;
            if (w_deq) r_rd_ptr <= ~r_rd_ptr;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Remember the last valid head slot so an empty queue keeps showing it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_show_ptr <= 1'b0;
        end else if (out_valid) begin
            r_show_ptr <= r_rd_ptr;
        end
    end

    assign w_head_ptr = out_valid ? r_rd_ptr : r_show_ptr;
    assign out_y      = w_slot_y[w_head_ptr];
    assign out_exc    = w_slot_exc[w_head_ptr];
    assign out_tag    = w_slot_tag[w_head_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky <= 1'b0;
        end else begin
            r_sticky <= (w_push && w_exc) || (r_sticky && !clear_sticky);
        end
    end

    assign sticky_exc = r_sticky;

`ifdef FSQRT_STAGE_PERF_EN
    logic [31:0] r_perf_ops;
    logic [31:0] r_perf_exc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_ops <= '0;
            r_perf_exc <= '0;
        end else if (w_push) begin
            r_perf_ops <= r_perf_ops + 32'd1;
            if (w_exc) r_perf_exc <= r_perf_exc + 32'd1;
        end
    end

    assign perf_ops = r_perf_ops;
    assign perf_exc = r_perf_exc;
`endif

endmodule

// File: doc/fsqrt_stage.md
Name: fsqrt_stage

Overview:
- Pipelined, handshaked execution stage around the existing combinational fsqrt datapath.
- Upstream, the FPU dispatch presents one operand per cycle with valid/ready. Downstream, writeback consumes results from a 2-entry output queue.
- Decouples the combinational sqrt path from dispatch and writeback timing.
- Carries a destination tag alongside each operation.
- Keeps a sticky exception flag for the CSR/status logic.

Parameters:
- TAG_W, 5: width of destination-register tag carried with each operation.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  operand valid from dispatch
- in_ready  out  1  stage can accept operand this cycle
- in_x  in  32  IEEE-754 single operand
- in_tag  in  TAG_W  destination tag
- out_valid  out  1  result at queue head valid
- out_ready  in  1  writeback consumes head this cycle
- out_y  out  32  sqrt result at queue head
- out_exc  out  1  fsqrt exception bit for head result
- out_tag  out  TAG_W  tag of head result
- flush  in  1  discard all in-flight operations
- clear_sticky  in  1  clear sticky exception flag
- sticky_exc  out  1  sticky OR of exceptions of all results enqueued

Behaviour:
- Reset: all of the following clear; data registers go to 0.
  - S1 valid, queue count and pointers, sticky_exc.
  - Visible reset values: out_valid=0, in_ready=1, out_y=0, out_exc=0, out_tag=0, sticky_exc=0.
- S1 operand register:
  - Holds {x, tag, valid}.
  - The fsqrt sub-module is combinational from S1.x.
- Output queue:
  - 2-entry circular FIFO of {y, exc, tag}; 1-bit rd/wr pointers; 2-bit count.
- Enqueue rule:
  - enq = S1.valid && (count<2 || deq).
  - deq = out_valid && out_ready.
- Input acceptance:
  - in_ready = !S1.valid || enq.
  - Accept = in_valid && in_ready; on accept, S1 loads in_x/in_tag.
  - If enq occurs without accept, S1.valid clears.
- Latency: operand accepted at edge k appears at queue head (out_valid=1) after edge k+1, given an empty queue or concurrent dequeue.
- Throughput: 1 op/cycle with out_ready held high.
- Capacity: 3 operations total (S1 plus 2 queue entries). in_ready is not asserted when S1 is full, count=2 and no deq.
- Simultaneous enq and deq with count=2 is legal; count stays 2.
- Ordering: results leave in acceptance order; the tag is passed unmodified.
- Exception handling:
  - out_exc is the fsqrt exception output captured at enqueue: operand sign=1 (including -0), or exponent=255 with mantissa≠0.
  - The stage does not reinterpret it.
  - out_y is the fsqrt result unchanged, within ±1 ulp of the true sqrt.
- Sticky flag:
  - sticky_exc is set on the cycle after an enq carrying exc=1.
  - clear_sticky clears it. If clear_sticky and a set occur in the same cycle, set wins.
- Flush:
  - Next edge clears S1.valid, count and pointers. Any same-cycle accept or enq is dropped.
  - sticky_exc is unaffected, except that an exception enqueued in the flush cycle does not set it.
- Reset mid-operation discards everything, identically to flush, plus it clears sticky_exc.
- out_* are driven from the queue head register contents. When out_valid=0 they hold their last value.

Optional Feature:
- Macro FSQRT_STAGE_PERF_EN.
- When defined:
  - Adds output ports perf_ops[31:0] and perf_exc[31:0].
  - perf_ops increments on each enq; perf_exc increments on each enq with exc=1.
  - Both wrap at 2^32, reset to 0, and are not cleared by flush.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared FPU package holds:
  - typedef float32_t (32-bit packed: sign, exp[7:0], man[22:0]);
  - constants EXP_INF=8'hFF and QUEUE_DEPTH=2.
- The sub-module is the existing fsqrt (x, y, exception), instantiated once.
- The queue is written inline; no separate FIFO module.

Test Plan:
- Single op:
  - Stimulus: in_x=0x40800000 (4.0), tag=3, out_ready=1.
  - Response: out_valid after 2 edges with out_y=0x40000000, out_exc=0, out_tag=3; sticky_exc stays 0.
- Exception:
  - Stimulus: in_x=0xBF800000 (-1.0), then in_x=0x7FC00000 (NaN).
  - Response: both results have out_exc=1; sticky_exc=1 after the first enq.
  - Then pulse clear_sticky: sticky_exc returns to 0.
- Back-pressure:
  - Stimulus: out_ready=0, stream 0x3F800000, 0x41100000, 0x41800000.
  - Response: all three accepted, then in_ready=0.
  - Raise out_ready: results come out in order, 0x3F800000, 0x40400000, 0x40800000.
- Full throughput with simultaneous enq/deq:
  - Stimulus: 100 random non-negative operands back-to-back with out_ready=1.
  - Response: one result per cycle, in order; each result within ±1 ulp of $sqrt.
- Flush and reset:
  - Stimulus: with 3 ops in flight, assert flush for 1 cycle.
  - Response: out_valid=0 and in_ready=1 next cycle.
  - Repeat with rst mid-stream: every output equals its reset value, including sticky_exc=0.
- Perf (FSQRT_STAGE_PERF_EN):
  - Stimulus: 5 ops, of which 2 are negative.
  - Response: perf_ops=5, perf_exc=2.
